// File: rtl/sram_block_controller.sv
// SRAM block controller for the 68k SRAM region: one-hot block select plus
// CE/OE/WE/byte-lane sequencing through a programmable wait-state FSM with DTACK.
`timescale 1ns/1ps
module sram_block_controller #(
    parameter int ADDR_WIDTH  = 17,
    parameter int NUM_BLOCKS  = 4,
    parameter int WAIT_STATES = 1
) (
    input  logic                  Clock,
    input  logic                  Reset_L,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic                  SRamSelect_H,
    input  logic                  AS_L,
    input  logic                  UDS_L,
    input  logic                  LDS_L,
    input  logic                  RW,
    output logic [NUM_BLOCKS-1:0] Block_H,
    output logic                  SRamCE_L,
    output logic                  SRamOE_L,
    output logic                  SRamWE_L,
    output logic                  SRamUB_L,
    output logic                  SRamLB_L,
    output logic                  Dtack_L,
    output logic                  Busy_H
);

    localparam int BLK_BITS = $clog2(NUM_BLOCKS);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_ACK     = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    localparam logic [NUM_BLOCKS-1:0] BLK_ONE  = NUM_BLOCKS'(1);
    localparam logic [3:0]            WAIT_TOP = 4'(WAIT_STATES - 1);

    logic [2:0]          state_r,     state_nxt_s;
    logic [3:0]          wait_cnt_r,  wait_cnt_nxt_s;
    logic [BLK_BITS-1:0] blk_idx_r,   blk_idx_nxt_s;
    logic                rw_r,        rw_nxt_s;
    logic                uds_r,       uds_nxt_s;
    logic                lds_r,       lds_nxt_s;

    logic                  start_s;
    logic                  active_nxt_s;
    logic [NUM_BLOCKS-1:0] block_nxt_s;
    logic                  ce_nxt_s, oe_nxt_s, we_nxt_s, ub_nxt_s, lb_nxt_s;
    logic                  dtack_nxt_s, busy_nxt_s;

    // Only the block-index bits of the address matter here.
    logic addr_unused_s;
    assign addr_unused_s = ^Address[ADDR_WIDTH-BLK_BITS-1:0];

    assign start_s = !AS_L && SRamSelect_H && (!UDS_L || !LDS_L);

    // Next-state, wait counter and access-attribute latch.
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = wait_cnt_r;
        blk_idx_nxt_s  = blk_idx_r;
        rw_nxt_s       = rw_r;
        uds_nxt_s      = uds_r;
        lds_nxt_s      = lds_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nxt_s   = ST_SETUP;
                    blk_idx_nxt_s = Address[ADDR_WIDTH-1 -: BLK_BITS];
                    rw_nxt_s      = RW;
                    uds_nxt_s     = UDS_L;
                    lds_nxt_s     = LDS_L;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (AS_L) begin
                    state_nxt_s    = ST_RELEASE;
                end else begin
                    state_nxt_s    = ST_WAIT;
                    wait_cnt_nxt_s = WAIT_TOP;
                end
            end
            ST_WAIT: begin
                // An address-strobe abort wins over reaching the last wait clock.
                if (AS_L) begin
                    state_nxt_s    = ST_RELEASE;
                end else if (wait_cnt_r == 4'd0) begin
                    state_nxt_s    = ST_ACK;
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r - 4'd1;
                end
            end
            ST_ACK: begin
                if (AS_L) begin
                    state_nxt_s = ST_RELEASE;
                end else begin
                    state_nxt_s = ST_ACK;
                end
            end
            ST_RELEASE: state_nxt_s = ST_IDLE;
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // Output values for the state being entered, so every output is a flop.
    always_comb begin
        active_nxt_s = (state_nxt_s == ST_SETUP) || (state_nxt_s == ST_WAIT) ||
                       (state_nxt_s == ST_ACK);
        if (active_nxt_s) begin
            block_nxt_s = BLK_ONE << blk_idx_nxt_s;
            ce_nxt_s    = 1'b0;
            oe_nxt_s    = !rw_nxt_s;
            ub_nxt_s    = uds_nxt_s;
            lb_nxt_s    = lds_nxt_s;
        end else begin
            block_nxt_s = {NUM_BLOCKS{1'b0}};
            ce_nxt_s    = 1'b1;
            oe_nxt_s    = 1'b1;
            ub_nxt_s    = 1'b1;
            lb_nxt_s    = 1'b1;
        end
        we_nxt_s    = !((state_nxt_s == ST_WAIT) && !rw_nxt_s);
        dtack_nxt_s = (state_nxt_s != ST_ACK);
        busy_nxt_s  = (state_nxt_s != ST_IDLE);
    end

    // State, latched access attributes and registered SRAM/68k outputs.
    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 4'd0;
            blk_idx_r  <= {BLK_BITS{1'b0}};
            rw_r       <= 1'b1;
            uds_r      <= 1'b1;
            lds_r      <= 1'b1;
            Block_H    <= {NUM_BLOCKS{1'b0}};
            SRamCE_L   <= 1'b1;
            SRamOE_L   <= 1'b1;
            SRamWE_L   <= 1'b1;
            SRamUB_L   <= 1'b1;
            SRamLB_L   <= 1'b1;
            Dtack_L    <= 1'b1;
            Busy_H     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
            blk_idx_r  <= blk_idx_nxt_s;
            rw_r       <= rw_nxt_s;
            uds_r      <= uds_nxt_s;
            lds_r      <= lds_nxt_s;
            Block_H    <= block_nxt_s;
            SRamCE_L   <= ce_nxt_s;
            SRamOE_L   <= oe_nxt_s;
            SRamWE_L   <= we_nxt_s;
            SRamUB_L   <= ub_nxt_s;
            SRamLB_L   <= lb_nxt_s;
            Dtack_L    <= dtack_nxt_s;
            Busy_H     <= busy_nxt_s;
        end
    end

endmodule

// File: tb/tb_sram_block_controller.sv
// Bench for sram_block_controller: two configurations (4 blocks/1 wait, 8 blocks/3 waits)
// share one 68k stimulus stream and are compared every cycle against an access-level model.
`timescale 1ns/1ps
module tb_sram_block_controller;

    logic        Clock = 1'b0;
    logic        Reset_L = 1'b0;
    logic [16:0] Address = 17'd0;
    logic        SRamSelect_H = 1'b0;
    logic        AS_L = 1'b1;
    logic        UDS_L = 1'b1;
    logic        LDS_L = 1'b1;
    logic        RW = 1'b1;

    logic [3:0] blk0;
    logic [7:0] blk1;
    logic ce0, oe0, we0, ub0, lb0, dt0, bz0;
    logic ce1, oe1, we1, ub1, lb1, dt1, bz1;

    sram_block_controller #(.ADDR_WIDTH(17), .NUM_BLOCKS(4), .WAIT_STATES(1)) dut0 (
        .Clock(Clock), .Reset_L(Reset_L), .Address(Address), .SRamSelect_H(SRamSelect_H),
        .AS_L(AS_L), .UDS_L(UDS_L), .LDS_L(LDS_L), .RW(RW),
        .Block_H(blk0), .SRamCE_L(ce0), .SRamOE_L(oe0), .SRamWE_L(we0),
        .SRamUB_L(ub0), .SRamLB_L(lb0), .Dtack_L(dt0), .Busy_H(bz0));

    sram_block_controller #(.ADDR_WIDTH(17), .NUM_BLOCKS(8), .WAIT_STATES(3)) dut1 (
        .Clock(Clock), .Reset_L(Reset_L), .Address(Address), .SRamSelect_H(SRamSelect_H),
        .AS_L(AS_L), .UDS_L(UDS_L), .LDS_L(LDS_L), .RW(RW),
        .Block_H(blk1), .SRamCE_L(ce1), .SRamOE_L(oe1), .SRamWE_L(we1),
        .SRamUB_L(ub1), .SRamLB_L(lb1), .Dtack_L(dt1), .Busy_H(bz1));

    always #5 Clock = ~Clock;

    int checks = 0;
    int passes = 0;

    localparam logic [22:0] IDLE_VEC = 23'h00007E;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int bb(input int i);
        return (i == 0) ? 2 : 3;
    endfunction

    function automatic int ws(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // Access-level model: phase 0 idle, 1 access in flight (age = clocks since start), 2 release.
    int         m_phase [2];
    int         m_age   [2];
    logic [3:0] m_idx   [2];
    logic       m_rw    [2];
    logic       m_uds   [2];
    logic       m_lds   [2];

    always @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            for (int i = 0; i < 2; i++) begin
                m_phase[i] <= 0;
                m_age[i]   <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                case (m_phase[i])
                    0: if (!AS_L && SRamSelect_H && (!UDS_L || !LDS_L)) begin
                        m_phase[i] <= 1;
                        m_age[i]   <= 0;
                        m_idx[i]   <= 4'(Address >> (17 - bb(i)));
                        m_rw[i]    <= RW;
                        m_uds[i]   <= UDS_L;
                        m_lds[i]   <= LDS_L;
                    end
                    1: if (AS_L) m_phase[i] <= 2;
                       else      m_age[i]   <= m_age[i] + 1;
                    default: m_phase[i] <= 0;
                endcase
            end
        end
    end

    function automatic logic [22:0] model_out(input int i);
        logic act;
        logic [15:0] blk;
        act = (m_phase[i] == 1);
        blk = act ? (16'd1 << m_idx[i]) : 16'd0;
        return {blk, !act, !(act && m_rw[i]),
                !(act && !m_rw[i] && m_age[i] >= 1 && m_age[i] <= ws(i)),
                act ? m_uds[i] : 1'b1, act ? m_lds[i] : 1'b1,
                !(act && m_age[i] > ws(i)), m_phase[i] != 0};
    endfunction

    function automatic logic [22:0] dut_out(input int i);
        if (i == 0) return {12'd0, blk0, ce0, oe0, we0, ub0, lb0, dt0, bz0};
        else        return {8'd0, blk1, ce1, oe1, we1, ub1, lb1, dt1, bz1};
    endfunction

    // Per-cycle compare of both configurations against the model.
    always @(negedge Clock) begin
        if (Reset_L) begin
            check("cycle_cfg0", 32'(dut_out(0)), 32'(model_out(0)));
            check("cycle_cfg1", 32'(dut_out(1)), 32'(model_out(1)));
        end
    end

    int         lat0, lat1, wec0, wec1;
    logic [3:0] first_blk0;
    logic [7:0] first_blk1;
    logic       first_ub0, first_lb0;

    task automatic go_idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge Clock); #2;
            AS_L = 1'b1; UDS_L = 1'b1; LDS_L = 1'b1; SRamSelect_H = 1'b0;
        end
    endtask

    // One 68k access; AS_L is sampled low at E0 and the following hold-1 edges.
    task automatic access(input logic [16:0] a, input logic r, input logic u, input logic l,
                          input int hold, input bit scramble);
        @(posedge Clock); #2;
        Address = a; RW = r; UDS_L = u; LDS_L = l; SRamSelect_H = 1'b1; AS_L = 1'b0;
        lat0 = -1; lat1 = -1; wec0 = 0; wec1 = 0;
        for (int k = 0; k < hold + 3; k++) begin
            @(posedge Clock); #2;
            if (k == hold - 1) begin
                AS_L = 1'b1; UDS_L = 1'b1; LDS_L = 1'b1; SRamSelect_H = 1'b0;
            end else if (scramble && k < hold - 1) begin
                Address = 17'($urandom); RW = 1'($urandom);
                SRamSelect_H = 1'($urandom); UDS_L = 1'($urandom); LDS_L = 1'($urandom);
            end
            @(negedge Clock);
            if (k == 0) begin
                first_blk0 = blk0; first_blk1 = blk1; first_ub0 = ub0; first_lb0 = lb0;
            end
            if (!dt0 && lat0 < 0) lat0 = k;
            if (!dt1 && lat1 < 0) lat1 = k;
            if (!we0) wec0++;
            if (!we1) wec1++;
        end
    endtask

    initial begin
        #12;
        check("reset_cfg0", 32'(dut_out(0)), 32'(IDLE_VEC));
        check("reset_cfg1", 32'(dut_out(1)), 32'(IDLE_VEC));
        @(negedge Clock); Reset_L = 1'b1;
        go_idle(2);

        // Word read of 17'h0A000: index 1 of 4, index 2 of 8.
        access(17'h0A000, 1'b1, 1'b0, 1'b0, 6, 1'b0);
        check("read_blk_cfg0", 32'(first_blk0), 32'h2);
        check("read_blk_cfg1", 32'(first_blk1), 32'h04);
        check("read_lat_cfg0", 32'(lat0), 32'd2);
        check("read_lat_cfg1", 32'(lat1), 32'd4);
        check("read_we_cfg0", 32'(wec0), 32'd0);

        // Upper-byte write of 17'h1C002: top block in both configurations.
        access(17'h1C002, 1'b0, 1'b0, 1'b1, 6, 1'b0);
        check("wr_blk_cfg0", 32'(first_blk0), 32'h8);
        check("wr_blk_cfg1", 32'(first_blk1), 32'h80);
        check("wr_ub_cfg0", 32'(first_ub0), 32'd0);
        check("wr_lb_cfg0", 32'(first_lb0), 32'd1);
        check("wr_we_cfg0", 32'(wec0), 32'd1);
        check("wr_we_cfg1", 32'(wec1), 32'd3);
        check("wr_lat_cfg0", 32'(lat0), 32'd2);

        // Read of 17'h1E000 with address/strobe noise after E0.
        access(17'h1E000, 1'b1, 1'b0, 1'b0, 7, 1'b1);
        check("rd8_blk_cfg1", 32'(first_blk1), 32'h80);
        check("rd8_lat_cfg1", 32'(lat1), 32'd4);

        // AS_L rises during WAIT: no DTACK, then a normal access follows.
        access(17'h04000, 1'b0, 1'b0, 1'b0, 2, 1'b0);
        check("abort_dtack_cfg0", 32'(lat0), 32'hFFFF_FFFF);
        check("abort_dtack_cfg1", 32'(lat1), 32'hFFFF_FFFF);
        check("abort_we_cfg1", 32'(wec1), 32'd1);
        access(17'h14000, 1'b1, 1'b1, 1'b0, 6, 1'b0);
        check("after_abort_lat_cfg0", 32'(lat0), 32'd2);
        check("after_abort_lat_cfg1", 32'(lat1), 32'd4);

        // Non-start conditions: SRAM not selected, and no data strobe.
        @(posedge Clock); #2;
        Address = 17'h0A000; RW = 1'b1; SRamSelect_H = 1'b0; AS_L = 1'b0; UDS_L = 1'b0; LDS_L = 1'b0;
        repeat (3) @(posedge Clock);
        #2; SRamSelect_H = 1'b1; UDS_L = 1'b1; LDS_L = 1'b1;
        repeat (3) @(posedge Clock);
        #2;
        check("nostart_busy_cfg0", 32'(bz0), 32'd0);
        check("nostart_blk_cfg1", 32'(blk1), 32'd0);
        go_idle(2);

        // Asynchronous reset during ACK of configuration 0.
        @(posedge Clock); #2;
        Address = 17'h0E000; RW = 1'b0; SRamSelect_H = 1'b1; AS_L = 1'b0; UDS_L = 1'b0; LDS_L = 1'b0;
        repeat (4) @(posedge Clock);
        #1; check("pre_reset_dtack_cfg0", 32'(dt0), 32'd0);
        #2; Reset_L = 1'b0;
        #1;
        check("async_reset_cfg0", 32'(dut_out(0)), 32'(IDLE_VEC));
        check("async_reset_cfg1", 32'(dut_out(1)), 32'(IDLE_VEC));
        AS_L = 1'b1; UDS_L = 1'b1; LDS_L = 1'b1;
        repeat (2) @(posedge Clock);
        #3; Reset_L = 1'b1;
        repeat (5) @(posedge Clock);
        #2; check("post_reset_busy_cfg0", 32'(bz0), 32'd0);

        // Randomised 68k bus traffic.
        for (int n = 0; n < 1500; n++) begin
            @(posedge Clock); #2;
            AS_L         = ($urandom_range(0, 3) == 0);
            SRamSelect_H = ($urandom_range(0, 3) != 0);
            UDS_L        = 1'($urandom);
            LDS_L        = 1'($urandom);
            RW           = 1'($urandom);
            Address      = 17'($urandom);
        end
        go_idle(4);
        @(negedge Clock);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
